// File: rtl/icache.sv
// Direct-mapped instruction cache with one 32-bit word per line. It looks up halfword-aligned
// fetches combinationally, including 32-bit instructions that straddle two words.
module icache #(
  parameter int unsigned INDEX_WIDTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_enable_in,
  input  logic [31:0] pc_in,
  output logic        ic_valid,
  output logic [31:0] ic_instr,
  output logic        ic2mc_req,
  output logic [31:0] ic2mc_addr,
  input  logic        mc2ic_ready,
  input  logic [31:0] mc2ic_data
);

  localparam int unsigned Lines    = 1 << INDEX_WIDTH;
  localparam int unsigned TagWidth = 30 - INDEX_WIDTH;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;

  logic [Lines-1:0]    valid_q;
  logic [TagWidth-1:0] tag_q  [Lines];
  logic [31:0]         data_q [Lines];

  logic [29:0]            w0, w1, miss_word;
  logic [INDEX_WIDTH-1:0] idx0, idx1, fill_idx;
  logic [TagWidth-1:0]    tag0, tag1, fill_tag;
  logic                   hit0, hit1, fill_we;
  logic [31:0]            data0;
  logic [15:0]            data1_lo, half_hi;
  logic                   unused_pc0;

  assign unused_pc0 = pc_in[0];

  // w1 wraps across the 30-bit word space, so its tag carries from w0's.
  assign w0       = pc_in[31:2];
  assign w1       = w0 + 30'd1;
  assign idx0     = w0[INDEX_WIDTH-1:0];
  assign idx1     = w1[INDEX_WIDTH-1:0];
  assign tag0     = w0[29:INDEX_WIDTH];
  assign tag1     = w1[29:INDEX_WIDTH];
  assign hit0     = valid_q[idx0] && (tag_q[idx0] == tag0);
  assign hit1     = valid_q[idx1] && (tag_q[idx1] == tag1);
  assign data0    = data_q[idx0];
  assign data1_lo = data_q[idx1][15:0];
  assign half_hi  = data0[31:16];

  assign miss_word = hit0 ? w1 : w0;
  assign fill_idx  = addr_q[INDEX_WIDTH+1:2];
  assign fill_tag  = addr_q[31:INDEX_WIDTH+2];

  assign ic2mc_req  = req_q;
  assign ic2mc_addr = addr_q;

  always_comb begin
    ic_valid = hit0;
    ic_instr = data0;
    if (!pc_in[1]) begin
      if (data0[1:0] != 2'b11) begin
        ic_instr = {16'h0000, data0[15:0]};
      end
    end else if (half_hi[1:0] == 2'b11) begin
      ic_valid = hit0 && hit1;
      ic_instr = {data1_lo, half_hi};
    end else begin
      ic_instr = {16'h0000, half_hi};
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    fill_we = 1'b0;
    if (rdy_in) begin
      unique case (state_q)
        StIdle: begin
          if (fetch_enable_in && !ic_valid) begin
            req_d   = 1'b1;
            addr_d  = {miss_word, 2'b00};
            state_d = StWait;
          end
        end
        StWait: begin
          // The request is never cancelled; a redirected pc is re-evaluated after the fill.
          if (mc2ic_ready) begin
            fill_we = 1'b1;
            req_d   = 1'b0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      addr_q  <= 32'h0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      if (fill_we) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill_we && !rst_in) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mc2ic_data;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios plus random fetch traffic, checked against a model that
// tracks which word address each line holds and reads instructions from a fixed memory image.
module tb_icache;

  localparam int NL = 256;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, fetch_enable_in;
  logic [31:0] pc_in;
  logic        ic_valid;
  logic [31:0] ic_instr;
  logic        ic2mc_req;
  logic [31:0] ic2mc_addr;
  logic        mc2ic_ready;
  logic [31:0] mc2ic_data;

  icache #(.INDEX_WIDTH(8)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .fetch_enable_in(fetch_enable_in),
    .pc_in          (pc_in),
    .ic_valid       (ic_valid),
    .ic_instr       (ic_instr),
    .ic2mc_req      (ic2mc_req),
    .ic2mc_addr     (ic2mc_addr),
    .mc2ic_ready    (mc2ic_ready),
    .mc2ic_data     (mc2ic_data)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: which word address each line holds; cached data always equals memory.
  bit          line_v [NL];
  logic [29:0] line_w [NL];
  bit          m_pend;
  logic [29:0] m_pw;
  logic [31:0] m_addr;
  int          m_cnt;
  int          mc_lat;
  bit          force_ready;
  logic [31:0] mem_over [logic [29:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    logic [31:0] x;
    if (mem_over.exists(w)) return mem_over[w];
    x = {2'b00, w};
    return (x * 32'h9E3779B1) ^ (x >> 3);
  endfunction

  function automatic bit m_hit(input logic [29:0] w);
    return line_v[w % NL] && (line_w[w % NL] == w);
  endfunction

  task automatic lookup(input logic [31:0] pc, output bit v, output logic [31:0] ins);
    logic [29:0] w0, w1;
    logic [31:0] d0, d1;
    logic [15:0] h;
    w0 = pc[31:2];
    w1 = w0 + 30'd1;
    d0 = mem_word(w0);
    d1 = mem_word(w1);
    h  = d0[31:16];
    if (!pc[1]) begin
      v   = m_hit(w0);
      ins = (d0[1:0] == 2'b11) ? d0 : {16'h0000, d0[15:0]};
    end else if (h[1:0] != 2'b11) begin
      v   = m_hit(w0);
      ins = {16'h0000, h};
    end else begin
      v   = m_hit(w0) && m_hit(w1);
      ins = {d1[15:0], h};
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registers.
  task automatic step(input bit rst, input bit rdy, input bit fe, input logic [31:0] pc);
    bit          v, fire, spur;
    logic [31:0] ins;
    @(negedge clk_in);
    rst_in          = rst;
    rdy_in          = rdy;
    fetch_enable_in = fe;
    pc_in           = pc;
    fire            = m_pend && (m_cnt == 0) && rdy;
    spur            = !m_pend && (force_ready || ($urandom_range(0, 9) == 0));
    mc2ic_ready     = fire || spur;
    mc2ic_data      = fire ? mem_word(m_pw) : $urandom;
    #1;
    lookup(pc, v, ins);
    chk("ic_valid", {31'b0, ic_valid}, {31'b0, v});
    if (v) chk("ic_instr", ic_instr, ins);
    if (rst) begin
      foreach (line_v[i]) line_v[i] = 1'b0;
      m_pend = 1'b0;
      m_addr = 32'h0;
    end else if (rdy) begin
      if (!m_pend) begin
        if (fe && !v) begin
          m_pend = 1'b1;
          m_pw   = m_hit(pc[31:2]) ? pc[31:2] + 30'd1 : pc[31:2];
          m_addr = {m_pw, 2'b00};
          m_cnt  = mc_lat - 1;
        end
      end else if (fire) begin
        line_v[m_pw % NL] = 1'b1;
        line_w[m_pw % NL] = m_pw;
        m_pend = 1'b0;
      end else begin
        m_cnt--;
      end
    end
    @(posedge clk_in);
    #1;
    chk("ic2mc_req", {31'b0, ic2mc_req}, {31'b0, m_pend});
    chk("ic2mc_addr", ic2mc_addr, m_addr);
  endtask

  task automatic fetch_until(input logic [31:0] pc, output int req_cyc);
    bit          v;
    logic [31:0] ins;
    int          n;
    req_cyc = 0;
    n       = 0;
    lookup(pc, v, ins);
    while (!v && n < 40) begin
      step(1'b0, 1'b1, 1'b1, pc);
      if (ic2mc_req) req_cyc++;
      n++;
      lookup(pc, v, ins);
    end
    if (!v) chk("fetch_timeout", {31'b0, v}, 32'd1);
  endtask

  // Combinational look at the current state without advancing the clock.
  task automatic peek(input string tag, input logic [31:0] pc, input bit exp_v,
                      input logic [31:0] exp_ins);
    pc_in           = pc;
    fetch_enable_in = 1'b0;
    #1;
    chk(tag, {31'b0, ic_valid}, {31'b0, exp_v});
    if (exp_v) chk(tag, ic_instr, exp_ins);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] base;
    case ($urandom_range(0, 3))
      0:       base = 32'($urandom_range(0, 63)) * 4;
      1:       base = 32'h400 + 32'($urandom_range(0, 15)) * 4;
      2:       base = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
      default: base = 32'h3F0 + 32'($urandom_range(0, 7)) * 4;
    endcase
    return base | (32'($urandom_range(0, 1)) << 1);
  endfunction

  initial begin
    int          rc;
    bit          v;
    logic [31:0] ins, pc;
    rst_in = 1'b1; rdy_in = 1'b1; fetch_enable_in = 1'b0; pc_in = 32'h0;
    mc2ic_ready = 1'b0; mc2ic_data = 32'h0;
    m_pend = 1'b0; m_addr = 32'h0; m_cnt = 0; m_pw = 30'h0; mc_lat = 3; force_ready = 1'b0;
    foreach (line_v[i]) begin line_v[i] = 1'b0; line_w[i] = 30'h0; end
    mem_over[30'h0] = 32'h0050_0093;
    mem_over[30'h1] = 32'h0093_8000;
    mem_over[30'h2] = 32'hAAAA_0567;
    mem_over[30'h4] = 32'h0001_4505;
    repeat (2) @(posedge clk_in);
    step(1'b1, 1'b1, 1'b0, 32'h0);

    // Cold fetch, ready three cycles after the request.
    fetch_until(32'h0, rc);
    chk("cold_req_cycles", 32'(rc), 32'd3);
    peek("cold_hit", 32'h0, 1'b1, 32'h0050_0093);

    // RVC in the upper half of a cached word hits with no request.
    fetch_until(32'h10, rc);
    peek("rvc_hit", 32'h12, 1'b1, 32'h0000_0001);
    step(1'b0, 1'b1, 1'b1, 32'h12);
    chk("rvc_noreq", {31'b0, ic2mc_req}, 32'd0);

    // Straddle with the second word absent.
    fetch_until(32'h4, rc);
    step(1'b0, 1'b1, 1'b1, 32'h6);
    chk("strad_addr", ic2mc_addr, 32'h8);
    fetch_until(32'h6, rc);
    peek("strad_hit", 32'h6, 1'b1, 32'h0567_0093);

    // Conflict on the same index evicts word 0.
    fetch_until(32'h400, rc);
    peek("conflict_miss", 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0);
    chk("conflict_addr", ic2mc_addr, 32'h0);
    fetch_until(32'h0, rc);

    // Redirect mid-wait: the old fill completes before the new pc is requested.
    mc_lat = 6;
    step(1'b0, 1'b1, 1'b1, 32'h40);
    step(1'b0, 1'b1, 1'b1, 32'h100);
    step(1'b0, 1'b1, 1'b1, 32'h100);
    chk("redir_hold", ic2mc_addr, 32'h40);
    fetch_until(32'h100, rc);
    lookup(32'h40, v, ins);
    peek("redir_line", 32'h40, 1'b1, ins);

    // Reset mid-wait, then a late ready pulse must not fill.
    mc_lat = 8;
    step(1'b0, 1'b1, 1'b1, 32'h200);
    step(1'b0, 1'b1, 1'b1, 32'h200);
    step(1'b1, 1'b1, 1'b0, 32'h200);
    force_ready = 1'b1;
    step(1'b0, 1'b1, 1'b0, 32'h200);
    force_ready = 1'b0;
    chk("rst_noreq", {31'b0, ic2mc_req}, 32'd0);
    peek("rst_miss", 32'h40, 1'b0, 32'h0);

    // Random traffic with stalls, resets and spurious ready pulses.
    pc = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      mc_lat = $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0) pc = rand_pc();
      step($urandom_range(0, 299) == 0, $urandom_range(0, 6) != 0,
           $urandom_range(0, 4) != 0, pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
